// File: rtl/fp16_pkg.sv
// Shared FP16 constants, state encoding and helpers for the MAC-cell datapath.
// Format: no subnormals, exp==0 means zero, truncation rounding.
package fp16_pkg;
    localparam int          DATA_W       = 16;
    localparam int          EXP_W        = 5;
    localparam int          MAN_W        = 10;
    localparam int          GUARD_W      = 3;
    localparam int          EXT_W        = MAN_W + GUARD_W + 1;  // hidden 1 + fraction + guard
    localparam int          RAW_W        = EXT_W + 1;            // plus carry
    localparam logic [15:0] FP16_ZERO    = 16'h0000;
    localparam logic [14:0] FP16_MAX_MAG = 15'h7BFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_e;

    // Leading-zero count of the raw adder result; returns RAW_W for zero.
    function automatic logic [3:0] lzc_raw(input logic [RAW_W-1:0] v);
        lzc_raw = 4'(RAW_W);
        for (int i = 0; i < RAW_W; i++) begin
            if (v[i]) lzc_raw = 4'(RAW_W - 1 - i);
        end
    endfunction
endpackage

// File: rtl/fp16_accum_if.sv
// Beat input / result output handshake bundle of the FP16 accumulator.
interface fp16_accum_if
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) ();
    logic              clr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ready;

    modport master (
        output clr, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  clr, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/fp16_add.sv
// Combinational two-operand FP16 adder: align, add/sub magnitudes, normalise, truncate.
// Shared with the reduction tree, so it carries no state.
module fp16_add
    import fp16_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum
);
    logic [EXP_W-1:0]   w_ea, w_eb, w_e_big, w_e_sml, w_shift;
    logic [EXT_W-1:0]   w_ma, w_mb, w_m_big, w_m_sml, w_sml_al;
    logic               w_swap, w_s_big, w_sub;
    logic [RAW_W-1:0]   w_raw;
    logic [3:0]         w_lz;
    logic signed [6:0]  w_exp;
    logic [MAN_W-1:0]   w_frac;

    // A zero exponent zeroes the whole operand, whatever its sign or fraction.
    assign w_ea = i_a[14:10];
    assign w_eb = i_b[14:10];
    assign w_ma = (w_ea == '0) ? '0 : {1'b1, i_a[MAN_W-1:0], {GUARD_W{1'b0}}};
    assign w_mb = (w_eb == '0) ? '0 : {1'b1, i_b[MAN_W-1:0], {GUARD_W{1'b0}}};

    assign w_swap  = {w_eb, w_mb} > {w_ea, w_ma};
    assign w_e_big = w_swap ? w_eb : w_ea;
    assign w_m_big = w_swap ? w_mb : w_ma;
    assign w_s_big = w_swap ? i_b[15] : i_a[15];
    assign w_e_sml = w_swap ? w_ea : w_eb;
    assign w_m_sml = w_swap ? w_ma : w_mb;

    assign w_shift  = w_e_big - w_e_sml;
    assign w_sml_al = (w_shift >= 5'(EXT_W)) ? '0 : (w_m_sml >> w_shift);

    // Larger magnitude sits first, so the subtraction never goes negative.
    assign w_sub = i_a[15] ^ i_b[15];
    assign w_raw = w_sub ? ({1'b0, w_m_big} - {1'b0, w_sml_al})
                         : ({1'b0, w_m_big} + {1'b0, w_sml_al});

    // Raw bit RAW_W-1 corresponds to exponent e_big+1.
    assign w_lz   = lzc_raw(w_raw);
    assign w_exp  = $signed({2'b00, w_e_big}) + 7'sd1 - $signed({3'b000, w_lz});
    assign w_frac = MAN_W'((w_raw << w_lz) >> (GUARD_W + 1));

    always_comb begin
        o_sum = FP16_ZERO;
        if (w_raw == '0 || w_exp < 7'sd1) begin
            o_sum = FP16_ZERO;
        end else if (w_exp > 7'sd30) begin
            o_sum = {w_s_big, FP16_MAX_MAG};
        end else begin
            o_sum = {w_s_big, w_exp[EXP_W-1:0], w_frac};
        end
    end
endmodule

// File: rtl/fp16_accum.sv
// Burst accumulator behind the MAC multiplier: sums FP16 beats and hands the
// finished sum plus beat count to the drain path over a valid/ready handshake.
module fp16_accum
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fp16_accum_if.slave   bus
);
    acc_state_e        r_state;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_out_cnt;

    logic [DATA_W-1:0] w_add_a;
    logic [DATA_W-1:0] w_sum;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_add_a   = (r_state == ST_IDLE) ? FP16_ZERO : r_acc;
    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    fp16_add u_add (
        .i_a   (w_add_a),
        .i_b   (bus.in_data),
        .o_sum (w_sum)
    );

    assign bus.in_ready  = (r_state != ST_DONE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_cnt   = r_out_cnt;

    // clr outranks both a last-beat accept and the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= FP16_ZERO;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= FP16_ZERO;
            r_out_cnt   <= '0;
        end else if (bus.clr) begin
            r_state     <= ST_IDLE;
            r_acc       <= FP16_ZERO;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_inc;
                        if (bus.in_last) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sum;
                            r_out_cnt   <= w_cnt_inc;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_acc       <= FP16_ZERO;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_accum.sv
// Directed + randomized bench for fp16_accum against an integer-arithmetic FP16 model.
module tb_fp16_accum;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp16_accum_if #(.CNT_W(CNT_W)) bus ();
    fp16_accum #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    logic [15:0] bq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value model: significand as an integer scaled by 8 (3 guard bits), aligned by
    // integer division, then renormalised by doubling/halving.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, eh, el, mh, ml, d, r, e;
        bit sa, sb, sh;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 8;
        mb = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 8;
        sa = a[15]; sb = b[15];
        if (eb > ea || (eb == ea && mb > ma)) begin
            eh = eb; mh = mb; sh = sb; el = ea; ml = ma;
        end else begin
            eh = ea; mh = ma; sh = sa; el = eb; ml = mb;
        end
        d  = eh - el;
        ml = (d >= 14) ? 0 : ml / (1 << d);
        r  = (sa == sb) ? mh + ml : mh - ml;
        if (r == 0) return 16'h0000;
        e = eh;
        while (r >= 16384) begin r = r / 2; e++; end
        while (r < 8192)   begin r = r * 2; e--; end
        if (e < 1)  return 16'h0000;
        if (e > 30) return {sh, 15'h7BFF};
        return {sh, 5'(e), 10'((r / 8) % 1024)};
    endfunction

    function automatic logic [15:0] model_sum();
        logic [15:0] acc = 16'h0000;
        foreach (bq[i]) acc = ref_add(acc, bq[i]);
        return acc;
    endfunction

    function automatic int model_cnt();
        return (bq.size() > CNT_MAX) ? CNT_MAX : bq.size();
    endfunction

    // Feed bq as one burst, check the result, stall `delay` cycles, then handshake.
    task automatic run_burst(input string tag, input logic [15:0] exp_data, input int exp_cnt,
                             input bit gaps, input int delay, input bit hold_valid);
        foreach (bq[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = bq[i];
            bus.in_last  = (i == bq.size() - 1);
            @(posedge clk); #1;
        end
        bus.in_valid = hold_valid;
        bus.in_data  = 16'h5555;
        bus.in_last  = 1'b1;
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".data"}, 32'(bus.out_data), 32'(exp_data));
        chk({tag, ".cnt"}, 32'(bus.out_cnt), 32'(exp_cnt));
        for (int k = 0; k < delay; k++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_data"}, 32'(bus.out_data), 32'(exp_data));
            chk({tag, ".hold_cnt"}, 32'(bus.out_cnt), 32'(exp_cnt));
            chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        chk({tag, ".drain"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic beat(input logic [15:0] d, input bit last, input bit clr);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last; bus.clr = clr;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.clr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;

        #3;
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.data", 32'(bus.out_data), 32'd0);
        chk("rst.cnt", 32'(bus.out_cnt), 32'd0);
        chk("rst.rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        bq = '{16'h3C00, 16'h3C00, 16'h3C00}; run_burst("ones3", 16'h4200, 3, 0, 0, 0);
        bq = '{16'h3C00, 16'hBC00};           run_burst("cancel", 16'h0000, 2, 0, 0, 0);
        bq = '{16'h6C00, 16'h3C00};           run_burst("trunc", 16'h6C00, 2, 0, 0, 0);
        bq = '{16'h6400, 16'h3C00};           run_burst("lsb", 16'h6401, 2, 0, 0, 0);
        bq = '{16'h7BFF, 16'h7BFF};           run_burst("sat", 16'h7BFF, 2, 0, 0, 0);
        bq = '{16'h0401, 16'h8400};           run_burst("flush", 16'h0000, 2, 0, 0, 0);
        bq = '{16'h0000, 16'hC000};           run_burst("zero_in", 16'hC000, 2, 0, 0, 0);
        bq = '{16'h8000};                     run_burst("negzero", 16'h0000, 1, 0, 0, 0);

        // Pending result with stalled consumer while upstream keeps offering beats.
        bq = '{16'h3C00, 16'h4000};           run_burst("stall", 16'h4200, 2, 0, 5, 1);
        bq = '{16'h4000};                     run_burst("after_stall", 16'h4000, 1, 0, 0, 0);

        // clr mid-burst, then a fresh burst.
        beat(16'h3C00, 0, 0);
        beat(16'h4400, 0, 1);
        chk("clr.mid_valid", 32'(bus.out_valid), 32'd0);
        bq = '{16'h4000};                     run_burst("post_clr", 16'h4000, 1, 0, 0, 0);

        // clr coincident with the last beat suppresses the result.
        beat(16'h3C00, 0, 0);
        beat(16'h3C00, 1, 1);
        chk("clr.last_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("clr.last_valid2", 32'(bus.out_valid), 32'd0);
        chk("clr.last_rdy", 32'(bus.in_ready), 32'd1);
        bq = '{16'h4400};                     run_burst("post_clr2", 16'h4400, 1, 0, 0, 0);

        // clr while a result is pending.
        beat(16'h3C00, 1, 0);
        chk("clr.done_pre", 32'(bus.out_valid), 32'd1);
        bus.clr = 1'b1; @(posedge clk); #1; bus.clr = 1'b0;
        chk("clr.done_valid", 32'(bus.out_valid), 32'd0);
        chk("clr.done_rdy", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-burst; out_data still holds the last result beforehand.
        beat(16'h3C00, 0, 0);
        bus.in_valid = 1'b1; bus.in_data = 16'h4000; bus.in_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(bus.out_valid), 32'd0);
        chk("arst.data", 32'(bus.out_data), 32'd0);
        chk("arst.cnt", 32'(bus.out_cnt), 32'd0);
        chk("arst.rdy", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.rdy_rel", 32'(bus.in_ready), 32'd1);
        bq = '{16'h3C00};                     run_burst("post_rst", 16'h3C00, 1, 0, 0, 0);

        // Long random burst: counter saturates.
        bq = {};
        for (int i = 0; i < 300; i++) begin
            v = 16'($urandom);
            v[14:10] = 5'($urandom_range(10, 20));
            bq.push_back(v);
        end
        run_burst("long", model_sum(), model_cnt(), 0, 0, 0);
        chk("long.cnt_sat", 32'(model_cnt()), 32'(CNT_MAX));

        // Random short bursts with input gaps and consumer backpressure.
        for (int b = 0; b < 12; b++) begin
            bq = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                v = 16'($urandom);
                if ($urandom_range(0, 3) != 0) v[14:10] = 5'($urandom_range(12, 18));
                bq.push_back(v);
            end
            run_burst($sformatf("rand%0d", b), model_sum(), model_cnt(), 1,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp16_accum.md
Name: fp16_accum

Overview:
- Downstream consumer of the FP16 multiplier in each MAC cell.
- Accumulates a burst of FP16 products, one beat per cycle, into a running FP16 sum.
- Presents the finished sum with a valid/ready handshake to the systolic-array drain path.
- Uses the multiplier's number format: no subnormals, all-zero encoding is zero, truncation rounding.

Parameters:
CNT_W, 8, width of the beat counter reported with each result

Ports:
clk        input   1      clock
rst_n      input   1      reset, asynchronous, active-low
clr        input   1      synchronous abort; discards partial sum
in_valid   input   1      product beat valid
in_data    input   16     FP16 product (sign, exp[14:10], mant[9:0])
in_last    input   1      final beat of burst, qualified by in_valid
in_ready   output  1      block accepts a beat this cycle
out_valid  output  1      result valid
out_data   output  16     accumulated FP16 sum
out_cnt    output  CNT_W  number of beats summed, saturating
out_ready  input   1      consumer accepts result

Behaviour:
- Reset values: state=IDLE, acc=0x0000, cnt=0, out_valid=0, out_data=0x0000, out_cnt=0. in_ready=1 after reset.
- States:
  - IDLE: no burst in progress.
  - ACC: burst in progress.
  - DONE: result held for the consumer.
- in_ready = (state != DONE). Combinational from state only; never depends on in_valid.
- Beat accept = in_valid & in_ready.
  - In IDLE, an accepted beat computes acc_next = 0 + in_data.
  - In ACC, an accepted beat computes acc_next = acc + in_data.
  - cnt increments on each accept and saturates at 2^CNT_W-1.
- IDLE/ACC transitions:
  - Accept with in_last=0 -> ACC.
  - Accept with in_last=1 -> DONE. Same edge: out_data <= acc_next, out_cnt <= cnt+1 (saturating), out_valid <= 1.
- Latency: result is visible the cycle after the last beat is accepted. A single beat with last gives out_data = in_data, normalised.
- In DONE:
  - out_valid, out_data and out_cnt are held stable until out_ready=1.
  - On that edge: out_valid <= 0, acc <= 0, cnt <= 0, state -> IDLE.
- Back-to-back bursts: the first beat of the next burst can only be accepted the cycle after the handshake, because in_ready=0 in DONE.
- clr has priority over every other event, including a simultaneous last-beat accept or out handshake. It forces IDLE, acc=0, cnt=0, out_valid=0.
- Adder (combinational, 1 cycle):
  - An operand with exp==0 is treated as zero (sign ignored).
  - Mantissas are extended to 14 bits: hidden 1, 10 fraction bits, 3 guard bits.
  - The smaller-exponent operand is right-shifted by the exponent difference. A shift >= 14 makes it 0.
  - Same sign: add; carry out -> shift right 1, exp+1.
  - Opposite sign: subtract the smaller magnitude from the larger. Result sign is that of the larger; on equal exponents compare mantissas.
  - Normalize by leading-one position, then truncate the guard bits.
- Exact cancellation -> 0x0000 (positive zero).
- Underflow (normalized exp < 1) -> 0x0000.
- Overflow (exp > 30) -> saturate to sign|0x7BFF.
- Inputs with exp==31 are never produced upstream; they are treated as ordinary values, so results saturate.
- Reset asserted mid-burst: everything returns to reset values immediately; the partial sum is lost.

Decomposition:
- Shared package fp16_pkg holds constants FP16_ZERO=16'h0000, FP16_MAX_MAG=15'h7BFF, EXP_W=5, MAN_W=10, GUARD_W=3.
- Sub-module fp16_add: purely combinational two-operand adder implementing the rules above. It is reused later by the reduction tree.
- fp16_accum holds the FSM, accumulator register, counter and output register.

Test Plan:
- Burst 0x3C00, 0x3C00, 0x3C00(last), in_valid held high -> out_valid one cycle after the third beat, out_data=0x4200, out_cnt=3.
- Burst 0x3C00, 0xBC00(last) -> out_data=0x0000. Burst 0x6C00, 0x3C00(last) -> 0x6C00 (truncated). Burst 0x6400, 0x3C00(last) -> 0x6401.
- Burst 0x7BFF, 0x7BFF(last) -> 0x7BFF. Burst 0x0401, 0x8400(last) -> 0x0000 (flush). Burst 0x0000, 0xC000(last) -> 0xC000.
- Result pending with out_ready=0 for 5 cycles while in_valid=1 -> out_data and out_cnt stable, in_ready=0, no beat accepted. Then out_ready=1 -> next cycle IDLE, in_ready=1.
- clr asserted on the 2nd beat of a 4-beat burst, then a fresh burst 0x4000(last) -> out_data=0x4000, out_cnt=1. clr coincident with the last beat -> no out_valid.
- rst_n asserted asynchronously mid-burst -> all outputs 0 immediately, in_ready=1 after release. Run 300 beats with CNT_W=8 -> out_cnt=255.
